// File: rtl/fp_add_unit_if.sv
// Issue/write-back bundle between the FP register file read ports and the FP adder.
interface fp_add_unit_if;
    logic        start;
    logic        op_sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        wr_en;

    modport master (
        output start, op_sub, a, b, rd,
        input  busy, done, result, rd_out, wr_en
    );

    modport slave (
        input  start, op_sub, a, b, rd,
        output busy, done, result, rd_out, wr_en
    );
endinterface

// File: rtl/fp_add_unit.sv
// Multi-cycle single-precision add/subtract, round-to-nearest-even, flush-to-zero.
// One operation in flight; fixed latency whatever the operands.
module fp_add_unit (
    input  logic         clk,
    input  logic         rst_n,
    fp_add_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t             state_q;
    logic               busy_q, done_q;
    logic [31:0]        result_q, res_q;
    logic [4:0]         rd_out_q, rd_q;
    logic [31:0]        a_q, b_q, spec_val_q;
    logic               sl_q, ss_q, spec_q, zero_q, zsign_q;
    logic signed [9:0]  exp_q;
    logic [26:0]        ml_q, ms_q, m_q;
    logic [27:0]        sum_q;

    // Index of the leading one counted from bit 26; caller guarantees v != 0.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd0;
        for (int i = 0; i < 27; i++)
            if (v[i]) lzc27 = 5'(26 - i);
    endfunction

    // Unpack, classify specials, order by magnitude, align the smaller operand.
    logic [7:0]  ea, eb, el, es, diff;
    logic [22:0] fa, fb;
    logic [26:0] mxa, mxb, ml_d, ms_raw, ms_d;
    logic        a_nan, b_nan, a_inf, b_inf, a_big, sl_d, ss_d, stk, spec_d;
    logic [31:0] spec_val_d;
    always_comb begin
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        fa     = (ea == 8'd0) ? 23'd0 : a_q[22:0];
        fb     = (eb == 8'd0) ? 23'd0 : b_q[22:0];
        mxa    = {ea != 8'd0, fa, 3'b000};
        mxb    = {eb != 8'd0, fb, 3'b000};
        a_big  = {ea, fa} >= {eb, fb};
        el     = a_big ? ea : eb;
        es     = a_big ? eb : ea;
        ml_d   = a_big ? mxa : mxb;
        ms_raw = a_big ? mxb : mxa;
        sl_d   = a_big ? a_q[31] : b_q[31];
        ss_d   = a_big ? b_q[31] : a_q[31];
        diff   = el - es;
        if (diff >= 8'd27) begin
            ms_d = 27'd0;
            stk  = |ms_raw;
        end else begin
            ms_d = ms_raw >> diff;
            stk  = |(ms_raw & ~({27{1'b1}} << diff));
        end
        ms_d[0] = ms_d[0] | stk;

        a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
        a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
        spec_d = a_nan | b_nan | a_inf | b_inf;
        if (a_nan | b_nan | (a_inf & b_inf & (a_q[31] != b_q[31])))
            spec_val_d = QNAN;
        else if (a_inf)
            spec_val_d = a_q;
        else
            spec_val_d = b_q;
    end

    // Normalize the raw sum: right by one on carry, else left by the leading-zero count.
    logic [4:0]        lz;
    logic [26:0]       norm_m_d;
    logic signed [9:0] norm_e_d;
    logic              norm_zero_d, zsign_d;
    always_comb begin
        lz          = lzc27(sum_q[26:0]);
        norm_m_d    = sum_q[26:0] << lz;
        norm_e_d    = exp_q - $signed({5'd0, lz});
        norm_zero_d = 1'b0;
        zsign_d     = sl_q;
        if (sum_q == 28'd0) begin
            norm_zero_d = 1'b1;
            zsign_d     = sl_q & ss_q;   // only (-0)+(-0) keeps the minus sign
        end else if (sum_q[27]) begin
            norm_m_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
            norm_e_d = exp_q + 10'sd1;
        end else if (norm_e_d <= 10'sd0) begin
            norm_zero_d = 1'b1;
        end
    end

    // Round to nearest even on G/R/S and pack; specials and zero override.
    logic              inc;
    logic [24:0]       m25;
    logic signed [9:0] rnd_e;
    logic [22:0]       frac;
    logic [31:0]       res_d;
    always_comb begin
        inc   = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
        m25   = {1'b0, m_q[26:3]} + {24'd0, inc};
        rnd_e = m25[24] ? exp_q + 10'sd1 : exp_q;
        frac  = m25[24] ? m25[23:1] : m25[22:0];
        if (spec_q)
            res_d = spec_val_q;
        else if (zero_q)
            res_d = {zsign_q, 31'd0};
        else if (rnd_e >= 10'sd255)
            res_d = {sl_q, 8'hFF, 23'd0};
        else
            res_d = {sl_q, rnd_e[7:0], frac};
    end

    // Sequencer: one stage per state; busy covers the whole op including the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 32'd0;
            rd_out_q   <= 5'd0;
            res_q      <= 32'd0;
            rd_q       <= 5'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            spec_val_q <= 32'd0;
            sl_q       <= 1'b0;
            ss_q       <= 1'b0;
            spec_q     <= 1'b0;
            zero_q     <= 1'b0;
            zsign_q    <= 1'b0;
            exp_q      <= 10'sd0;
            ml_q       <= 27'd0;
            ms_q       <= 27'd0;
            m_q        <= 27'd0;
            sum_q      <= 28'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= bus.start;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b ^ {bus.op_sub, 31'd0};
                        rd_q    <= bus.rd;
                        state_q <= ALIGN;
                    end
                end
                ALIGN: begin
                    sl_q       <= sl_d;
                    ss_q       <= ss_d;
                    ml_q       <= ml_d;
                    ms_q       <= ms_d;
                    exp_q      <= $signed({2'b00, el});
                    spec_q     <= spec_d;
                    spec_val_q <= spec_val_d;
                    state_q    <= ADD;
                end
                ADD: begin
                    sum_q   <= (sl_q == ss_q) ? {1'b0, ml_q} + {1'b0, ms_q}
                                              : {1'b0, ml_q} - {1'b0, ms_q};
                    state_q <= NORM;
                end
                NORM: begin
                    m_q     <= norm_m_d;
                    exp_q   <= norm_e_d;
                    zero_q  <= norm_zero_d;
                    zsign_q <= zsign_d;
                    state_q <= ROUND;
                end
                ROUND: begin
                    res_q   <= res_d;
                    state_q <= DONE;
                end
                DONE: begin
                    result_q <= res_q;
                    rd_out_q <= rd_q;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
    assign bus.wr_en  = done_q & (rd_out_q != 5'd0);
endmodule
